// File: rtl/alu_issue_queue.sv
// Command FIFO in front of a combinational ALU with a registered, handshaked result stage.
// Optional ALU_ISSUE_STATS_EN adds stat_done/stat_zero/stat_carry handshake counters.
module alu_issue_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2:0]               in_op,

    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_op,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_carry,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic                     out_carry,
    output logic [2:0]               out_op,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]              stat_done,
    output logic [31:0]              stat_zero,
    output logic [31:0]              stat_carry
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem_a  [DEPTH];
    logic [WIDTH-1:0] r_mem_b  [DEPTH];
    logic [2:0]       r_mem_op [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_zero;
    logic             r_out_carry;
    logic [2:0]       r_out_op;

    logic             w_empty;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_arith;

    assign w_empty    = (r_count == '0);
    // Full is judged before any pop this cycle, so there is no pop-to-push bypass.
    assign w_in_ready = (r_count != FULL_COUNT);
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = !w_empty && (!r_out_valid || out_ready);
    assign w_arith    = (alu_op == 3'b000) || (alu_op == 3'b001);

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!w_empty) begin
            alu_a  = r_mem_a[r_rd_ptr];
            alu_b  = r_mem_b[r_rd_ptr];
            alu_op = r_mem_op[r_rd_ptr];
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= in_a;
            r_mem_b[r_wr_ptr]  <= in_b;
            r_mem_op[r_wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_carry  <= 1'b0;
            r_out_op     <= '0;
        end else if (w_pop) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_zero   <= alu_zero;
            // Carry is only meaningful for add/sub.
            r_out_carry  <= w_arith ? alu_carry : 1'b0;
            r_out_op     <= alu_op;
        end else if (r_out_valid && out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_carry  = r_out_carry;
    assign out_op     = r_out_op;
    assign count      = r_count;

`ifdef ALU_ISSUE_STATS_EN
    logic        w_out_hs;
    logic [31:0] r_stat_done;
    logic [31:0] r_stat_zero;
    logic [31:0] r_stat_carry;

    assign w_out_hs = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_done  <= '0;
            r_stat_zero  <= '0;
            r_stat_carry <= '0;
        end else if (w_out_hs) begin
            r_stat_done <= r_stat_done + 32'd1;
            if (r_out_zero) begin
                r_stat_zero <= r_stat_zero + 32'd1;
            end
            if (r_out_carry) begin
                r_stat_carry <= r_stat_carry + 32'd1;
            end
        end
    end

    assign stat_done  = r_stat_done;
    assign stat_zero  = r_stat_zero;
    assign stat_carry = r_stat_carry;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: behavioural ALU plus a queue-based model checked every cycle,
// directed literal checks first, then randomized traffic.
module tb_alu_issue_queue;

    localparam int W = 32;
    localparam int D = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_carry;
    logic [2:0]  out_op;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    cmd_t        q[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_result = '0;
    logic        m_zero = 1'b0;
    logic        m_carry = 1'b0;
    logic [2:0]  m_op = '0;

    always #5 clk = ~clk;

    alu_issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_op     (out_op),
        .count      (count)
    );

    // Returns {carry, zero, result}; carry for logic/shift ops is deliberately non-zero
    // at times so the forced-zero rule is exercised.
    function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        logic [31:0] r;
        logic        c;
        case (op)
            3'd0: {c, r} = {1'b0, a} + {1'b0, b};
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: begin r = a & b; c = a[0]; end
            3'd3: begin r = a | b; c = a[0]; end
            3'd4: begin r = a ^ b; c = a[0]; end
            3'd5: begin r = ~(a & b); c = a[0]; end
            3'd6: begin r = a << 1; c = a[31]; end
            default: begin r = a >> 1; c = a[0]; end
        endcase
        return {c, (r == 32'd0), r};
    endfunction

    always_comb {alu_carry, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        bit          do_push;
        bit          do_fire;
        cmd_t        h;
        logic [33:0] r;
        if (!rst_n) begin
            q.delete();
            m_valid  = 1'b0;
            m_result = '0;
            m_zero   = 1'b0;
            m_carry  = 1'b0;
            m_op     = '0;
        end else begin
            do_push = in_valid && (q.size() < D);
            do_fire = (q.size() != 0) && (!m_valid || out_ready);
            if (do_fire) begin
                h        = q.pop_front();
                r        = alu_fn(h.a, h.b, h.op);
                m_result = r[31:0];
                m_zero   = r[32];
                m_carry  = (h.op <= 3'd1) ? r[33] : 1'b0;
                m_op     = h.op;
                m_valid  = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (do_push) q.push_back({in_a, in_b, in_op});
        end
    end

    always @(negedge clk) begin : compare
        cmd_t h;
        if (rst_n && cmp_en) begin
            h = (q.size() != 0) ? q[0] : '0;
            chk("count", 32'(count), 32'(q.size()));
            chk("in_ready", 32'(in_ready), 32'(q.size() != D));
            chk("alu_a", alu_a, h.a);
            chk("alu_b", alu_b, h.b);
            chk("alu_op", 32'(alu_op), 32'(h.op));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_result", out_result, m_result);
            chk("out_zero", 32'(out_zero), 32'(m_zero));
            chk("out_carry", 32'(out_carry), 32'(m_carry));
            chk("out_op", 32'(out_op), 32'(m_op));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst count", 32'(count), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_result", out_result, 0);
        chk("rst out_carry", 32'(out_carry), 0);
        chk("rst out_op", 32'(out_op), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 1);
        tick();

        // Single add, one-edge latency
        out_ready = 1'b1;
        set_cmd(32'd5, 32'd7, 3'd0);
        tick();
        in_valid = 1'b0;
        chk("t1 latency", 32'(out_valid), 0);
        tick();
        chk("t1 valid", 32'(out_valid), 1);
        chk("t1 result", out_result, 32'd12);
        chk("t1 zero", 32'(out_zero), 0);
        chk("t1 carry", 32'(out_carry), 0);
        tick();

        // Add overflow then sub to zero
        set_cmd(32'hFFFF_FFFF, 32'd1, 3'd0);
        tick();
        set_cmd(32'd3, 32'd3, 3'd1);
        tick();
        in_valid = 1'b0;
        chk("t2a result", out_result, 32'd0);
        chk("t2a zero", 32'(out_zero), 1);
        chk("t2a carry", 32'(out_carry), 1);
        tick();
        chk("t2b result", out_result, 32'd0);
        chk("t2b zero", 32'(out_zero), 1);
        chk("t2b carry", 32'(out_carry), 0);
        chk("t2b op", 32'(out_op), 1);
        tick();

        // Fill under backpressure, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(32'(i + 1), 32'd100, 3'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("t3 count full", 32'(count), 4);
        chk("t3 in_ready", 32'(in_ready), 0);
        chk("t3 held result", out_result, 32'd101);
        out_ready = 1'b1;
        set_cmd(32'hDEAD_BEEF, 32'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        chk("t3 no bypass", 32'(count), 3);
        chk("t3 second", out_result, 32'd102);
        repeat (5) tick();
        chk("t3 drained", 32'(count), 0);
        chk("t3 idle", 32'(out_valid), 0);

        // Shifts: carry forced to zero
        set_cmd(32'h8000_0001, 32'd0, 3'd6);
        tick();
        set_cmd(32'h8000_0001, 32'd0, 3'd7);
        tick();
        in_valid = 1'b0;
        chk("t4 shl", out_result, 32'h0000_0002);
        chk("t4 shl carry", 32'(out_carry), 0);
        tick();
        chk("t4 shr", out_result, 32'h4000_0000);
        chk("t4 shr carry", 32'(out_carry), 0);
        tick();

        // Streaming
        for (int i = 0; i < 20; i++) begin
            set_cmd($urandom, $urandom, 3'($urandom_range(0, 7)));
            tick();
            chk("t5 count<=1", 32'(count <= 3'd1), 1);
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(32'(i + 20), 32'd1, 3'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("t6 queued", 32'(count), 3);
        chk("t6 pending", 32'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6 rst count", 32'(count), 0);
        chk("t6 rst valid", 32'(out_valid), 0);
        chk("t6 rst result", out_result, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_cmd(32'd9, 32'd4, 3'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6 new valid", 32'(out_valid), 1);
        chk("t6 new result", out_result, 32'd5);
        tick();
        chk("t6 only one", 32'(out_valid), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       in_a = 32'hFFFF_FFFF;
                1:       in_a = 32'd0;
                default: in_a = $urandom;
            endcase
            in_b  = ($urandom_range(0, 4) == 0) ? in_a : $urandom;
            in_op = 3'($urandom_range(0, 7));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        chk("final empty", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
